cache_controller_dm: RTL and testbench

Parametrised direct-mapped cache controller for single-word CPU accesses, with block-wide refills and evictions to the memory interface. It holds its own tag, valid, dirty and data arrays. Compared with the earlier fixed-geometry controller it adds configurable sets and block size, selectable write-back or write-through policy, byte enables, level-held memory handshakes and a whole-cache flush. It sits between the CPU load/store port and the block-transfer memory port.

---
 rtl/cache_controller_dm.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_cache_controller_dm.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_controller_dm.sv
// Direct-mapped cache controller: single-word CPU port, block-wide refill/evict memory port,
// write-back or write-through policy, byte enables and a whole-cache flush walker.
module cache_controller_dm #(
    parameter int unsigned NUM_SETS        = 128,
    parameter int unsigned WORDS_PER_BLOCK = 16,
    parameter bit          WRITE_BACK      = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cpu_read,
    input  logic                          cpu_write,
    input  logic [31:0]                   cpu_addr,
    input  logic [31:0]                   cpu_write_data,
    input  logic [3:0]                    cpu_byte_en,
    output logic [31:0]                   cpu_read_data,
    output logic                          cpu_ready,
    input  logic                          flush,
    output logic                          flush_done,
    output logic                          busy,
    output logic                          mem_read,
    output logic                          mem_write,
    output logic [31:0]                   mem_addr,
    output logic [32*WORDS_PER_BLOCK-1:0] mem_write_data,
    input  logic [32*WORDS_PER_BLOCK-1:0] mem_read_data,
    input  logic                          mem_ready
);

    localparam int unsigned INDEX_W    = $clog2(NUM_SETS);
    localparam int unsigned WORD_W     = $clog2(WORDS_PER_BLOCK);
    localparam int unsigned OFFSET_W   = WORD_W + 2;
    localparam int unsigned TAG_W      = 32 - INDEX_W - OFFSET_W;
    localparam int unsigned BLOCK_BITS = 32 * WORDS_PER_BLOCK;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_EVICT,
        S_FILL,
        S_WTHRU,
        S_FLUSH_SCAN,
        S_FLUSH_WB
    } state_e;

    state_e state_q, state_d;

    logic [BLOCK_BITS-1:0] data_q [NUM_SETS];
    logic [TAG_W-1:0]      tag_q  [NUM_SETS];
    logic [NUM_SETS-1:0]   valid_q, valid_d;
    logic [NUM_SETS-1:0]   dirty_q, dirty_d;

    logic [31:0]           req_addr_q, req_addr_d;
    logic [31:0]           req_data_q, req_data_d;
    logic [3:0]            req_be_q, req_be_d;
    logic                  req_wr_q, req_wr_d;
    logic [INDEX_W-1:0]    scan_idx_q, scan_idx_d;

    logic [31:0]           cpu_read_data_q, cpu_read_data_d;
    logic                  cpu_ready_q, cpu_ready_d;
    logic                  flush_done_q, flush_done_d;
    logic                  busy_q, busy_d;
    logic                  mem_read_q, mem_read_d;
    logic                  mem_write_q, mem_write_d;
    logic [31:0]           mem_addr_q, mem_addr_d;
    logic [BLOCK_BITS-1:0] mem_write_data_q, mem_write_data_d;

    logic [TAG_W-1:0]      req_tag;
    logic [INDEX_W-1:0]    req_idx;
    logic [WORD_W+4:0]     word_base;
    logic [BLOCK_BITS-1:0] cur_line, merged_line, line_wdata, scan_line;
    logic [31:0]           req_blk, victim_blk, scan_blk;
    logic                  hit, victim_dirty, scan_dirty, scan_last;
    logic                  line_we, tag_we;
    logic                  unused_addr_bits;

    assign req_tag      = req_addr_q[31 -: TAG_W];
    assign req_idx      = req_addr_q[OFFSET_W +: INDEX_W];
    assign word_base    = {req_addr_q[2 +: WORD_W], 5'd0};
    assign cur_line     = data_q[req_idx];
    assign hit          = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign victim_dirty = valid_q[req_idx] && dirty_q[req_idx];
    assign req_blk      = {req_tag, req_idx, OFFSET_W'(0)};
    assign victim_blk   = {tag_q[req_idx], req_idx, OFFSET_W'(0)};
    assign scan_line    = data_q[scan_idx_q];
    assign scan_blk     = {tag_q[scan_idx_q], scan_idx_q, OFFSET_W'(0)};
    assign scan_dirty   = valid_q[scan_idx_q] && dirty_q[scan_idx_q];
    assign scan_last    = (scan_idx_q == INDEX_W'(NUM_SETS - 1));
    assign unused_addr_bits = ^req_addr_q[1:0];

    // Store data merged into the addressed word under the byte enables
    always_comb begin
        merged_line = cur_line;
        for (int b = 0; b < 4; b++) begin
            if (req_be_q[b]) begin
                merged_line[32'(word_base) + 32'(8 * b) +: 8] = req_data_q[8 * b +: 8];
            end
        end
    end

    always_comb begin
        state_d          = state_q;
        req_addr_d       = req_addr_q;
        req_data_d       = req_data_q;
        req_be_d         = req_be_q;
        req_wr_d         = req_wr_q;
        scan_idx_d       = scan_idx_q;
        valid_d          = valid_q;
        dirty_d          = dirty_q;
        cpu_read_data_d  = cpu_read_data_q;
        cpu_ready_d      = 1'b0;
        flush_done_d     = 1'b0;
        mem_read_d       = mem_read_q;
        mem_write_d      = mem_write_q;
        mem_addr_d       = mem_addr_q;
        mem_write_data_d = mem_write_data_q;
        line_we          = 1'b0;
        tag_we           = 1'b0;
        line_wdata       = merged_line;

        case (state_q)
            S_IDLE: begin
                // Skip the cycle after a completion pulse so a still-held request is not re-taken
                if (!cpu_ready_q && !flush_done_q) begin
                    if (flush) begin
                        state_d    = S_FLUSH_SCAN;
                        scan_idx_d = '0;
                    end else if (cpu_read || cpu_write) begin
                        req_addr_d = cpu_addr;
                        req_data_d = cpu_write_data;
                        req_be_d   = cpu_byte_en;
                        req_wr_d   = cpu_write;
                        state_d    = S_LOOKUP;
                    end
                end
            end
            S_LOOKUP: begin
                if (hit) begin
                    if (!req_wr_q) begin
                        cpu_read_data_d = cur_line[32'(word_base) +: 32];
                        cpu_ready_d     = 1'b1;
                        state_d         = S_IDLE;
                    end else begin
                        line_we = 1'b1;
                        if (WRITE_BACK) begin
                            dirty_d[req_idx] = 1'b1;
                            cpu_ready_d      = 1'b1;
                            state_d          = S_IDLE;
                        end else begin
                            mem_write_d      = 1'b1;
                            mem_addr_d       = req_blk;
                            mem_write_data_d = merged_line;
                            state_d          = S_WTHRU;
                        end
                    end
                end else if (victim_dirty) begin
                    mem_write_d      = 1'b1;
                    mem_addr_d       = victim_blk;
                    mem_write_data_d = cur_line;
                    state_d          = S_EVICT;
                end else begin
                    mem_read_d = 1'b1;
                    mem_addr_d = req_blk;
                    state_d    = S_FILL;
                end
            end
            S_EVICT: begin
                if (mem_ready) begin
                    dirty_d[req_idx] = 1'b0;
                    mem_write_d      = 1'b0;
                    mem_read_d       = 1'b1;
                    mem_addr_d       = req_blk;
                    state_d          = S_FILL;
                end
            end
            S_FILL: begin
                if (mem_ready) begin
                    line_we          = 1'b1;
                    line_wdata       = mem_read_data;
                    tag_we           = 1'b1;
                    valid_d[req_idx] = 1'b1;
                    dirty_d[req_idx] = 1'b0;
                    mem_read_d       = 1'b0;
                    state_d          = S_LOOKUP;
                end
            end
            S_WTHRU: begin
                if (mem_ready) begin
                    mem_write_d = 1'b0;
                    cpu_ready_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            S_FLUSH_SCAN: begin
                if (scan_dirty) begin
                    mem_write_d      = 1'b1;
                    mem_addr_d       = scan_blk;
                    mem_write_data_d = scan_line;
                    state_d          = S_FLUSH_WB;
                end else if (scan_last) begin
                    flush_done_d = 1'b1;
                    state_d      = S_IDLE;
                end else begin
                    scan_idx_d = scan_idx_q + INDEX_W'(1);
                end
            end
            S_FLUSH_WB: begin
                if (mem_ready) begin
                    dirty_d[scan_idx_q] = 1'b0;
                    mem_write_d         = 1'b0;
                    if (scan_last) begin
                        flush_done_d = 1'b1;
                        state_d      = S_IDLE;
                    end else begin
                        scan_idx_d = scan_idx_q + INDEX_W'(1);
                        state_d    = S_FLUSH_SCAN;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= S_IDLE;
            valid_q          <= '0;
            dirty_q          <= '0;
            req_addr_q       <= '0;
            req_data_q       <= '0;
            req_be_q         <= '0;
            req_wr_q         <= 1'b0;
            scan_idx_q       <= '0;
            cpu_read_data_q  <= '0;
            cpu_ready_q      <= 1'b0;
            flush_done_q     <= 1'b0;
            busy_q           <= 1'b0;
            mem_read_q       <= 1'b0;
            mem_write_q      <= 1'b0;
            mem_addr_q       <= '0;
            mem_write_data_q <= '0;
        end else begin
            state_q          <= state_d;
            valid_q          <= valid_d;
            dirty_q          <= dirty_d;
            req_addr_q       <= req_addr_d;
            req_data_q       <= req_data_d;
            req_be_q         <= req_be_d;
            req_wr_q         <= req_wr_d;
            scan_idx_q       <= scan_idx_d;
            cpu_read_data_q  <= cpu_read_data_d;
            cpu_ready_q      <= cpu_ready_d;
            flush_done_q     <= flush_done_d;
            busy_q           <= busy_d;
            mem_read_q       <= mem_read_d;
            mem_write_q      <= mem_write_d;
            mem_addr_q       <= mem_addr_d;
            mem_write_data_q <= mem_write_data_d;
        end
    end

    // Line storage is not reset; valid bits gate its use
    always_ff @(posedge clk) begin
        if (line_we) begin
            data_q[req_idx] <= line_wdata;
        end
        if (tag_we) begin
            tag_q[req_idx] <= req_tag;
        end
    end

    assign cpu_read_data  = cpu_read_data_q;
    assign cpu_ready      = cpu_ready_q;
    assign flush_done     = flush_done_q;
    assign busy           = busy_q;
    assign mem_read       = mem_read_q;
    assign mem_write      = mem_write_q;
    assign mem_addr       = mem_addr_q;
    assign mem_write_data = mem_write_data_q;

endmodule

// File: tb/tb_cache_controller_dm.sv
// Bench for cache_controller_dm: a default write-back instance and a small write-through
// instance share one CPU stimulus port; a responder models the block memory.
module tb_cache_controller_dm;

    logic clk;
    logic rst;
    logic sel;
    logic cpu_read, cpu_write;
    logic [31:0] cpu_addr, cpu_wdata;
    logic [3:0] cpu_be;
    logic a_flush;
    logic mem_en;

    logic a_rd, a_wr, b_rd, b_wr;
    assign a_rd = cpu_read & ~sel;
    assign a_wr = cpu_write & ~sel;
    assign b_rd = cpu_read & sel;
    assign b_wr = cpu_write & sel;

    logic [31:0]  a_rdata, a_mem_addr, b_rdata, b_mem_addr;
    logic         a_ready, a_fdone, a_busy, a_mem_read, a_mem_write, a_mem_ready;
    logic         b_ready, b_fdone, b_busy, b_mem_read, b_mem_write, b_mem_ready;
    logic [511:0] a_mem_wdata, a_mrd;
    logic [63:0]  b_mem_wdata, b_mrd;

    cache_controller_dm u_a (
        .clk(clk), .rst(rst), .cpu_read(a_rd), .cpu_write(a_wr), .cpu_addr(cpu_addr),
        .cpu_write_data(cpu_wdata), .cpu_byte_en(cpu_be), .cpu_read_data(a_rdata),
        .cpu_ready(a_ready), .flush(a_flush), .flush_done(a_fdone), .busy(a_busy),
        .mem_read(a_mem_read), .mem_write(a_mem_write), .mem_addr(a_mem_addr),
        .mem_write_data(a_mem_wdata), .mem_read_data(a_mrd), .mem_ready(a_mem_ready)
    );

    cache_controller_dm #(.NUM_SETS(4), .WORDS_PER_BLOCK(2), .WRITE_BACK(1'b0)) u_b (
        .clk(clk), .rst(rst), .cpu_read(b_rd), .cpu_write(b_wr), .cpu_addr(cpu_addr),
        .cpu_write_data(cpu_wdata), .cpu_byte_en(cpu_be), .cpu_read_data(b_rdata),
        .cpu_ready(b_ready), .flush(1'b0), .flush_done(b_fdone), .busy(b_busy),
        .mem_read(b_mem_read), .mem_write(b_mem_write), .mem_addr(b_mem_addr),
        .mem_write_data(b_mem_wdata), .mem_read_data(b_mrd), .mem_ready(b_mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Refill pattern: word i of every block is base + i
    initial begin
        for (int i = 0; i < 16; i++) a_mrd[i * 32 +: 32] = 32'hA000_0000 + 32'(i);
        for (int i = 0; i < 2; i++) b_mrd[i * 32 +: 32] = 32'hB000_0000 + 32'(i);
    end

    typedef struct {
        bit           wr;
        logic [31:0]  addr;
        logic [511:0] data;
    } txn_t;
    txn_t log_q[$];

    // Memory model: answers each request two cycles after it is seen, logging it
    int a_w, b_w;
    always @(posedge clk) begin
        if (rst) begin
            a_mem_ready <= 1'b0;
            b_mem_ready <= 1'b0;
            a_w <= 0;
            b_w <= 0;
        end else begin
            if (a_mem_ready) a_mem_ready <= 1'b0;
            else if ((a_mem_read || a_mem_write) && mem_en) begin
                if (a_w == 1) begin
                    a_mem_ready <= 1'b1;
                    a_w <= 0;
                    log_q.push_back('{a_mem_write, a_mem_addr, a_mem_wdata});
                end else a_w <= a_w + 1;
            end else a_w <= 0;
            if (b_mem_ready) b_mem_ready <= 1'b0;
            else if ((b_mem_read || b_mem_write) && mem_en) begin
                if (b_w == 1) begin
                    b_mem_ready <= 1'b1;
                    b_w <= 0;
                    log_q.push_back('{b_mem_write, b_mem_addr, 512'(b_mem_wdata)});
                end else b_w <= b_w + 1;
            end else b_w <= 0;
        end
    end

    // Protocol monitor: no simultaneous requests, address stable while a request is pending
    int mon_errs;
    logic a_req_p, a_rdy_p;
    logic [31:0] a_addr_p;
    initial mon_errs = 0;
    always @(posedge clk) begin
        a_req_p  <= a_mem_read | a_mem_write;
        a_rdy_p  <= a_mem_ready;
        a_addr_p <= a_mem_addr;
        if ((a_mem_read && a_mem_write) || (b_mem_read && b_mem_write) ||
            (!rst && (a_mem_read | a_mem_write) && a_req_p && !a_rdy_p && a_mem_addr != a_addr_p))
            mon_errs <= mon_errs + 1;
    end

    int checks, errors;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic access(input bit s, input bit wr, input logic [31:0] addr,
                          input logic [31:0] d, input logic [3:0] be,
                          output logic [31:0] rd, output int lat, output bit ok);
        sel = s;
        log_q.delete();
        cpu_addr = addr; cpu_wdata = d; cpu_be = be;
        cpu_write = wr; cpu_read = ~wr;
        lat = 0;
        do begin
            @(posedge clk); #1; lat++;
        end while (!(s ? b_ready : a_ready) && lat < 300);
        ok = s ? b_ready : a_ready;
        rd = s ? b_rdata : a_rdata;
        cpu_read = 1'b0; cpu_write = 1'b0;
        @(posedge clk); #1;
    endtask

    // Latency counts edges from the one sampling flush to the one raising flush_done
    task automatic do_flush(output int lat, output bit ok, output bit stuck);
        sel = 1'b0;
        log_q.delete();
        a_flush = 1'b1;
        @(posedge clk); #1;
        a_flush = 1'b0;
        lat = 1;
        while (!a_fdone && lat < 3000) begin
            @(posedge clk); #1; lat++;
        end
        ok = a_fdone;
        @(posedge clk); #1;
        stuck = a_fdone;
    endtask

    typedef struct {
        bit sel; bit wr; logic [31:0] addr; logic [31:0] wdata; logic [3:0] be;
        bit chk_rd; logic [31:0] exp_rd; int nrd; int nwr;
        bit chk_a0; logic [31:0] exp_a0; int lat; bit chk_w; int w_idx; logic [31:0] w_val;
    } vec_t;

    function automatic vec_t mk(bit s, bit wr, logic [31:0] a, logic [31:0] d, logic [3:0] be,
                                bit crd, logic [31:0] erd, int nrd, int nwr, bit ca,
                                logic [31:0] ea, int lat, bit cw, int wi, logic [31:0] wv);
        vec_t v;
        v.sel = s; v.wr = wr; v.addr = a; v.wdata = d; v.be = be;
        v.chk_rd = crd; v.exp_rd = erd; v.nrd = nrd; v.nwr = nwr;
        v.chk_a0 = ca; v.exp_a0 = ea; v.lat = lat; v.chk_w = cw; v.w_idx = wi; v.w_val = wv;
        return v;
    endfunction

    vec_t vecs[14];

    initial begin
        logic [31:0] rd;
        int lat, nrd, nwr, fw, pulses;
        bit ok, stuck;
        string nm;

        checks = 0; errors = 0;
        sel = 0; cpu_read = 0; cpu_write = 0; cpu_addr = 0; cpu_wdata = 0; cpu_be = 0;
        a_flush = 0; mem_en = 1; rst = 1;

        //          sel wr addr          wdata         be       crd exp_rd        nrd nwr ca exp_a0     lat cw wi w_val
        vecs[0]  = mk(0, 0, 32'h0000_1040, 32'h0,        4'h0,    1, 32'hA000_0000, 1, 0, 1, 32'h0000_1040, 0, 0, 0, 32'h0);
        vecs[1]  = mk(0, 0, 32'h0000_1044, 32'h0,        4'h0,    1, 32'hA000_0001, 0, 0, 0, 32'h0,         2, 0, 0, 32'h0);
        vecs[2]  = mk(0, 1, 32'h0000_1048, 32'h1122_3344, 4'b0101, 0, 32'h0,        0, 0, 0, 32'h0,         2, 0, 0, 32'h0);
        vecs[3]  = mk(0, 0, 32'h0000_1048, 32'h0,        4'h0,    1, 32'hA022_0044, 0, 0, 0, 32'h0,         2, 0, 0, 32'h0);
        vecs[4]  = mk(0, 0, 32'h0000_3048, 32'h0,        4'h0,    1, 32'hA000_0002, 1, 1, 1, 32'h0000_1040, 0, 1, 2, 32'hA022_0044);
        vecs[5]  = mk(0, 0, 32'h0000_1040, 32'h0,        4'h0,    1, 32'hA000_0000, 1, 0, 1, 32'h0000_1040, 0, 0, 0, 32'h0);
        vecs[6]  = mk(0, 1, 32'h0000_0044, 32'hDEAD_BEEF, 4'hF,   0, 32'h0,        1, 0, 1, 32'h0000_0040, 0, 0, 0, 32'h0);
        vecs[7]  = mk(0, 0, 32'h0000_0044, 32'h0,        4'h0,    1, 32'hDEAD_BEEF, 0, 0, 0, 32'h0,         2, 0, 0, 32'h0);
        vecs[8]  = mk(0, 1, 32'h0000_0148, 32'h7700_0000, 4'b1000, 0, 32'h0,        1, 0, 1, 32'h0000_0140, 0, 0, 0, 32'h0);
        vecs[9]  = mk(0, 0, 32'h0000_0148, 32'h0,        4'h0,    1, 32'h7700_0002, 0, 0, 0, 32'h0,         2, 0, 0, 32'h0);
        vecs[10] = mk(1, 0, 32'h0000_0008, 32'h0,        4'h0,    1, 32'hB000_0000, 1, 0, 1, 32'h0000_0008, 0, 0, 0, 32'h0);
        vecs[11] = mk(1, 1, 32'h0000_000C, 32'h1234_5678, 4'hF,   0, 32'h0,        0, 1, 1, 32'h0000_0008, 0, 1, 1, 32'h1234_5678);
        vecs[12] = mk(1, 0, 32'h0000_000C, 32'h0,        4'h0,    1, 32'h1234_5678, 0, 0, 0, 32'h0,         2, 0, 0, 32'h0);
        vecs[13] = mk(1, 0, 32'h0000_0028, 32'h0,        4'h0,    1, 32'hB000_0000, 1, 0, 1, 32'h0000_0028, 0, 0, 0, 32'h0);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdata", 64'(a_rdata), 64'h0);
        chk("rst_ready_done_busy", 64'({a_ready, a_fdone, a_busy}), 64'h0);
        chk("rst_mem_req", 64'({a_mem_read, a_mem_write}), 64'h0);
        chk("rst_mem_addr", 64'(a_mem_addr), 64'h0);
        chk("rst_mem_wdata_zero", 64'(a_mem_wdata == '0), 64'h1);
        rst = 0;
        @(posedge clk); #1;

        foreach (vecs[k]) begin
            access(vecs[k].sel, vecs[k].wr, vecs[k].addr, vecs[k].wdata, vecs[k].be, rd, lat, ok);
            nm = $sformatf("v%0d", k);
            chk({nm, "_ready"}, 64'(ok), 64'h1);
            if (vecs[k].chk_rd) chk({nm, "_rdata"}, 64'(rd), 64'(vecs[k].exp_rd));
            nrd = 0; nwr = 0; fw = -1;
            foreach (log_q[j]) begin
                if (log_q[j].wr) begin
                    nwr++;
                    if (fw < 0) fw = j;
                end else nrd++;
            end
            chk({nm, "_nread"}, 64'(nrd), 64'(vecs[k].nrd));
            chk({nm, "_nwrite"}, 64'(nwr), 64'(vecs[k].nwr));
            if (vecs[k].chk_a0) chk({nm, "_addr0"}, (log_q.size() > 0) ? 64'(log_q[0].addr) : 64'hDEAD, 64'(vecs[k].exp_a0));
            if (vecs[k].lat != 0) chk({nm, "_latency"}, 64'(lat), 64'(vecs[k].lat));
            if (vecs[k].chk_w) chk({nm, "_wword"}, (fw >= 0) ? 64'(log_q[fw].data[vecs[k].w_idx * 32 +: 32]) : 64'hDEAD, 64'(vecs[k].w_val));
        end

        // Flush with sets 1 and 5 dirty: two ascending write-backs, one done pulse
        do_flush(lat, ok, stuck);
        chk("flush1_done", 64'(ok), 64'h1);
        chk("flush1_single_pulse", 64'(stuck), 64'h0);
        chk("flush1_nwrite", 64'(log_q.size()), 64'h2);
        if (log_q.size() == 2) begin
            chk("flush1_addr0", 64'(log_q[0].addr), 64'h40);
            chk("flush1_addr1", 64'(log_q[1].addr), 64'h140);
            chk("flush1_data0_w1", 64'(log_q[0].data[32 +: 32]), 64'hDEAD_BEEF);
            chk("flush1_data1_w2", 64'(log_q[1].data[64 +: 32]), 64'h7700_0002);
            chk("flush1_both_writes", 64'({log_q[0].wr, log_q[1].wr}), 64'h3);
        end

        // Clean cache: no traffic, done NUM_SETS+1 edges after flush is sampled
        do_flush(lat, ok, stuck);
        chk("flush2_done", 64'(ok), 64'h1);
        chk("flush2_nwrite", 64'(log_q.size()), 64'h0);
        chk("flush2_latency", 64'(lat), 64'd129);

        // Previously flushed line still valid: read hit returns stored data
        access(0, 0, 32'h0000_0044, 32'h0, 4'h0, rd, lat, ok);
        chk("post_flush_hit", 64'(rd), 64'hDEAD_BEEF);
        chk("post_flush_no_mem", 64'(log_q.size()), 64'h0);

        // Reset while a fill waits on mem_ready
        sel = 0; mem_en = 0; log_q.delete();
        cpu_addr = 32'h0000_2000; cpu_read = 1;
        repeat (4) @(posedge clk);
        #1;
        chk("rstfill_mem_read_pending", 64'({a_mem_read, a_busy}), 64'h3);
        rst = 1; cpu_read = 0;
        @(posedge clk); #1;
        chk("rstfill_mem_read_dropped", 64'({a_mem_read, a_mem_write, a_busy}), 64'h0);
        rst = 0; mem_en = 1;
        pulses = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (a_ready) pulses++;
        end
        chk("rstfill_no_ready", 64'(pulses), 64'h0);
        access(0, 0, 32'h0000_2000, 32'h0, 4'h0, rd, lat, ok);
        chk("rstfill_reread_ready", 64'(ok), 64'h1);
        chk("rstfill_reread_miss", 64'(log_q.size()), 64'h1);
        chk("rstfill_reread_data", 64'(rd), 64'hA000_0000);

        chk("protocol_monitor", 64'(mon_errs), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
